alu_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the ALU and drives all of its control and operand inputs. It buffers operation requests in a small FIFO, issues each one to the ALU as a single-cycle enable pulse on port A or port B, and captures the ALU result and interrupt. It clears the interrupt when required and returns a result response over a valid/ready channel. One command is in flight at a time.

---
 rtl/alu_cmd_seq_pkg.sv | 33 +++
 rtl/alu_cmd_seq_if.sv | 44 ++++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_cmd_seq.sv | 118 +++++++++++
 tb/tb_alu_cmd_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// Shared ALU types plus the command-sequencer payload and FSM state encoding.
package alu_cmd_seq_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP1 = 2'd0,
    OP2 = 2'd1,
    OP3 = 2'd2,
    OP4 = 2'd3
  } opcode_t;

  typedef logic [DATA_W-1:0] data_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic    port;
    opcode_t op;
    data_t   a;
    data_t   b;
  } alu_cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    CLEAR   = 3'd3,
    RESP    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Command, response and ALU-control bundle of the command sequencer.
interface alu_cmd_seq_if;
  import alu_cmd_seq_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  logic    cmd_port;
  opcode_t cmd_op;
  data_t   cmd_a;
  data_t   cmd_b;

  logic    rsp_valid;
  logic    rsp_ready;
  data_t   rsp_data;
  logic    rsp_irq;

  logic    alu_enable;
  logic    alu_enable_a;
  logic    alu_enable_b;
  opcode_t alu_op_a;
  opcode_t alu_op_b;
  data_t   alu_in_a;
  data_t   alu_in_b;
  logic    alu_irq_clr;
  data_t   alu_out;
  logic    alu_irq;

  // master: command producer, response consumer and the ALU itself
  modport master (
    output cmd_valid, cmd_port, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_irq,
    input  cmd_ready, rsp_valid, rsp_data, rsp_irq,
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    input  alu_in_a, alu_in_b, alu_irq_clr
  );

  // slave: the sequencer
  modport slave (
    input  cmd_valid, cmd_port, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_irq,
    output cmd_ready, rsp_valid, rsp_data, rsp_irq,
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    output alu_in_a, alu_in_b, alu_irq_clr
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty are registered from the next occupancy.
module alu_cmd_fifo
  import alu_cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     alu_clk,
  input  logic     alu_rst_n,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t rd_data_c,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: pointer reset discards the contents.
  always_ff @(posedge alu_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: FIFO-buffered commands issued one at a time to the ALU.
// Optional statistics counters are built only when ALU_SEQ_STATS_EN is defined.
module alu_cmd_seq
  import alu_cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  alu_cmd_seq_if.slave     bus,
  output logic [CNT_W-1:0] cnt_cmd,
  output logic [CNT_W-1:0] cnt_irq
);

  seq_state_t state;
  alu_cmd_t   push_cmd;
  alu_cmd_t   head_c;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  assign push_cmd      = '{port: bus.cmd_port, op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  assign push          = bus.cmd_valid && !fifo_full;
  assign pop           = (state == IDLE) && !fifo_empty;
  assign bus.cmd_ready = !fifo_full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .alu_clk   (alu_clk),
    .alu_rst_n (alu_rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .rd_data_c (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer FSM; enables and irq_clr default low so they pulse for one cycle.
  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state            <= IDLE;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_irq      <= 1'b0;
      bus.alu_enable   <= 1'b0;
      bus.alu_enable_a <= 1'b0;
      bus.alu_enable_b <= 1'b0;
      bus.alu_op_a     <= OP1;
      bus.alu_op_b     <= OP1;
      bus.alu_in_a     <= '0;
      bus.alu_in_b     <= '0;
      bus.alu_irq_clr  <= 1'b0;
    end else begin
      bus.alu_enable   <= 1'b0;
      bus.alu_enable_a <= 1'b0;
      bus.alu_enable_b <= 1'b0;
      bus.alu_irq_clr  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            bus.alu_in_a     <= head_c.a;
            bus.alu_in_b     <= head_c.b;
            bus.alu_enable   <= 1'b1;
            bus.alu_enable_a <= (head_c.port == PORT_A);
            bus.alu_enable_b <= (head_c.port == PORT_B);
            if (head_c.port == PORT_A) bus.alu_op_a <= head_c.op;
            else                       bus.alu_op_b <= head_c.op;
            state <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          bus.rsp_data <= bus.alu_out;
          bus.rsp_irq  <= bus.alu_irq;
          if (bus.alu_irq) begin
            bus.alu_irq_clr <= 1'b1;
            state           <= CLEAR;
          end else begin
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        CLEAR: begin
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating issue / interrupt counters.
  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      cnt_cmd <= '0;
      cnt_irq <= '0;
    end else begin
      if ((state == ISSUE) && (cnt_cmd != '1))
        cnt_cmd <= cnt_cmd + CNT_W'(1);
      if ((state == CAPTURE) && bus.alu_irq && (cnt_irq != '1))
        cnt_irq <= cnt_irq + CNT_W'(1);
    end
  end
`else
  assign cnt_cmd = '0;
  assign cnt_irq = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Randomized self-checking bench for alu_cmd_seq with an in-bench ALU and queue-based reference model.
module tb_alu_cmd_seq;
  import alu_cmd_seq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             alu_clk   = 1'b0;
  logic             alu_rst_n = 1'b0;
  logic [CNT_W-1:0] cnt_cmd;
  logic [CNT_W-1:0] cnt_irq;

  alu_cmd_seq_if bus();

  alu_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .alu_clk   (alu_clk),
    .alu_rst_n (alu_rst_n),
    .bus       (bus.slave),
    .cnt_cmd   (cnt_cmd),
    .cnt_irq   (cnt_irq)
  );

  always #5 alu_clk = ~alu_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU function table used both by the ALU stand-in and the reference model
  function automatic data_t alu_calc(input logic port, input opcode_t op, input data_t a, input data_t b);
    if (port == PORT_A) begin
      case (op)
        OP1:     return a & b;
        OP2:     return ~(a & b);
        OP3:     return a | b;
        default: return ~(a | b);
      endcase
    end else begin
      case (op)
        OP1:     return a ^ b;
        OP2:     return a + b;
        OP3:     return a - b;
        default: return ~(a ^ b);
      endcase
    end
  endfunction

  function automatic bit is_hold(input logic port, input opcode_t op, input data_t b);
    return (port == PORT_A) && (op == OP1) && (b == 8'h00);
  endfunction

  // Expected {irq, data} for a command: hold returns 0, irq when result is in 0xF0..0xFF
  function automatic logic [8:0] expect_rsp(input alu_cmd_t c);
    data_t d;
    if (is_hold(c.port, c.op, c.b)) return 9'h000;
    d = alu_calc(c.port, c.op, c.a, c.b);
    return {(d >= 8'hF0), d};
  endfunction

  // ALU stand-in: registers result on an enable, clears output when idle
  always @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      bus.alu_out <= '0;
      bus.alu_irq <= 1'b0;
    end else if (bus.alu_enable && (bus.alu_enable_a ^ bus.alu_enable_b)) begin
      if (!is_hold(bus.alu_enable_b, bus.alu_enable_b ? bus.alu_op_b : bus.alu_op_a, bus.alu_in_b)) begin
        bus.alu_out <= alu_calc(bus.alu_enable_b, bus.alu_enable_b ? bus.alu_op_b : bus.alu_op_a,
                                bus.alu_in_a, bus.alu_in_b);
        bus.alu_irq <= (alu_calc(bus.alu_enable_b, bus.alu_enable_b ? bus.alu_op_b : bus.alu_op_a,
                                 bus.alu_in_a, bus.alu_in_b) >= 8'hF0);
      end
    end else begin
      bus.alu_out <= '0;
      if (bus.alu_irq_clr) bus.alu_irq <= 1'b0;
    end
  end

  // Reference model state
  alu_cmd_t    pend_q[$];
  alu_cmd_t    resp_q[$];
  alu_cmd_t    cur;
  opcode_t     last_op_a, last_op_b;
  data_t       last_a, last_b;
  logic        en_d1, en_d2, en_d3;
  logic [8:0]  back_r, head_r;
  logic        exp_clr;
  int unsigned m_cmd, m_irq;
  int unsigned rsp_count = 0;
  int unsigned clr_count = 0;

  // Per-cycle compare against the model
  initial forever begin
    @(negedge alu_clk);
    if (!alu_rst_n) begin
      pend_q.delete();
      resp_q.delete();
      last_op_a = OP1; last_op_b = OP1; last_a = '0; last_b = '0;
      en_d1 = 1'b0; en_d2 = 1'b0; en_d3 = 1'b0;
      m_cmd = 0; m_irq = 0;
      check("reset_state",
            !bus.rsp_valid && bus.rsp_data == 8'h00 && !bus.rsp_irq && !bus.alu_enable &&
            !bus.alu_enable_a && !bus.alu_enable_b && !bus.alu_irq_clr && bus.cmd_ready &&
            bus.alu_in_a == 8'h00 && bus.alu_in_b == 8'h00 && bus.alu_op_a == OP1 &&
            bus.alu_op_b == OP1 && cnt_cmd == '0 && cnt_irq == '0,
            {bus.rsp_valid, bus.alu_enable, bus.alu_irq_clr, bus.cmd_ready}, 32'h1);
    end else begin
      if (bus.alu_enable) begin
        if (pend_q.size() == 0) begin
          check("spurious_issue", 1'b0, 1, 0);
        end else begin
          cur = pend_q.pop_front();
          check("issue_port", {bus.alu_enable_a, bus.alu_enable_b} == ((cur.port == PORT_B) ? 2'b01 : 2'b10),
                {bus.alu_enable_a, bus.alu_enable_b}, (cur.port == PORT_B) ? 2'b01 : 2'b10);
          if (cur.port == PORT_A) last_op_a = cur.op;
          else                    last_op_b = cur.op;
          last_a = cur.a;
          last_b = cur.b;
          resp_q.push_back(cur);
        end
      end else begin
        check("enables_low", !bus.alu_enable_a && !bus.alu_enable_b,
              {bus.alu_enable_a, bus.alu_enable_b}, 0);
      end
      check("alu_op_a", bus.alu_op_a == last_op_a, bus.alu_op_a, last_op_a);
      check("alu_op_b", bus.alu_op_b == last_op_b, bus.alu_op_b, last_op_b);
      check("alu_in_a", bus.alu_in_a == last_a, bus.alu_in_a, last_a);
      check("alu_in_b", bus.alu_in_b == last_b, bus.alu_in_b, last_b);
      check("one_in_flight", !(bus.rsp_valid && bus.alu_enable), {bus.rsp_valid, bus.alu_enable}, 0);

      back_r = (resp_q.size() > 0) ? expect_rsp(resp_q[$]) : 9'h000;
      exp_clr = en_d2 && (resp_q.size() > 0) && back_r[8];
      check("irq_clr", bus.alu_irq_clr == exp_clr, bus.alu_irq_clr, exp_clr);
      if (resp_q.size() > 0 && ((en_d2 && !back_r[8]) || (en_d3 && back_r[8])))
        check("rsp_latency", bus.rsp_valid, bus.rsp_valid, 1);

`ifdef ALU_SEQ_STATS_EN
      check("cnt_cmd", cnt_cmd == CNT_W'(m_cmd), cnt_cmd, m_cmd);
      check("cnt_irq", cnt_irq == CNT_W'(m_irq), cnt_irq, m_irq);
      if (bus.alu_enable && m_cmd < (2**CNT_W - 1)) m_cmd++;
      if (en_d1 && back_r[8] && m_irq < (2**CNT_W - 1)) m_irq++;
`else
      check("cnt_tied", cnt_cmd == '0 && cnt_irq == '0, {cnt_cmd, cnt_irq}, 0);
`endif

      if (bus.rsp_valid) begin
        if (resp_q.size() == 0) begin
          check("spurious_rsp", 1'b0, 1, 0);
        end else begin
          head_r = expect_rsp(resp_q[0]);
          check("rsp_data", bus.rsp_data == head_r[7:0], bus.rsp_data, head_r[7:0]);
          check("rsp_irq", bus.rsp_irq == head_r[8], bus.rsp_irq, head_r[8]);
          if (bus.rsp_ready) begin
            void'(resp_q.pop_front());
            rsp_count++;
          end
        end
      end

      check("cmd_ready", bus.cmd_ready == (pend_q.size() != DEPTH), bus.cmd_ready, pend_q.size() != DEPTH);
      if (bus.alu_irq_clr) clr_count++;
      en_d3 = en_d2;
      en_d2 = en_d1;
      en_d1 = bus.alu_enable;
      if (bus.cmd_valid && bus.cmd_ready)
        pend_q.push_back(alu_cmd_t'{bus.cmd_port, bus.cmd_op, bus.cmd_a, bus.cmd_b});
    end
  end

  task automatic tick();
    @(posedge alu_clk);
    #1;
  endtask

  task automatic send(input logic port, input opcode_t op, input data_t a, input data_t b);
    bit acc;
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_port  = port;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      acc = bus.cmd_ready;
      tick();
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 1'b0, n, 200);
  endtask

  task automatic send_rand();
    data_t b;
    b = ($urandom_range(0, 7) == 0) ? 8'h00 : data_t'($urandom);
    send(1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 3)), data_t'($urandom), b);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend_q.size() != 0 || resp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 3000, n, 3000);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready == 1'b1, bus.cmd_ready, 1);
    check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_data, bus.rsp_irq} == 10'h000,
          {bus.rsp_valid, bus.rsp_data, bus.rsp_irq}, 0);
    check({tag, "_enables"}, {bus.alu_enable, bus.alu_enable_a, bus.alu_enable_b, bus.alu_irq_clr} == 4'h0,
          {bus.alu_enable, bus.alu_enable_a, bus.alu_enable_b, bus.alu_irq_clr}, 0);
    check({tag, "_operands"}, {bus.alu_in_a, bus.alu_in_b} == 16'h0000, {bus.alu_in_a, bus.alu_in_b}, 0);
    check({tag, "_opcodes"}, bus.alu_op_a == OP1 && bus.alu_op_b == OP1, {bus.alu_op_a, bus.alu_op_b}, 0);
    check({tag, "_counters"}, cnt_cmd == '0 && cnt_irq == '0, {cnt_cmd, cnt_irq}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, limit %0d", 500000);
    $fatal(1, "watchdog");
  end

  initial begin
    int       lat;
    int       c0;
    int       r0;
    bit       done;
    bit       acc;
    data_t    d0;
    logic     i0;
    alu_cmd_t lit;

    bus.cmd_valid = 1'b0;
    bus.cmd_port  = PORT_A;
    bus.cmd_op    = OP1;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    tick();
    check_reset_vals("por");
    tick();
    tick();
    alu_rst_n = 1'b1;
    tick();

    // model anchors
    lit = alu_cmd_t'{PORT_A, OP3, 8'hF0, 8'h08};
    check("model_a_op3", expect_rsp(lit) == 9'h1F8, expect_rsp(lit), 9'h1F8);
    lit = alu_cmd_t'{PORT_B, OP1, 8'h0F, 8'hFE};
    check("model_b_op1", expect_rsp(lit) == 9'h1F1, expect_rsp(lit), 9'h1F1);
    lit = alu_cmd_t'{PORT_A, OP1, 8'h55, 8'h00};
    check("model_hold", expect_rsp(lit) == 9'h000, expect_rsp(lit), 9'h000);

    // port A OP3 with interrupt
    c0 = int'(clr_count);
    send(PORT_A, OP3, 8'hF0, 8'h08);
    wait_rsp(lat);
    check("lat_irq", lat == 4, lat, 4);
    check("t1_data", bus.rsp_data == 8'hF8, bus.rsp_data, 8'hF8);
    check("t1_irq", bus.rsp_irq == 1'b1, bus.rsp_irq, 1);
    drain();
    check("t1_clr_once", int'(clr_count) - c0 == 1, int'(clr_count) - c0, 1);

    // port B OP1 with interrupt
    send(PORT_B, OP1, 8'h0F, 8'hFE);
    wait_rsp(lat);
    check("lat_irq_b", lat == 4, lat, 4);
    check("t2_data", bus.rsp_data == 8'hF1, bus.rsp_data, 8'hF1);
    check("t2_irq", bus.rsp_irq == 1'b1, bus.rsp_irq, 1);
    drain();

    // ALU hold case returns zero
    send(PORT_A, OP1, 8'h55, 8'h00);
    wait_rsp(lat);
    check("lat_plain", lat == 3, lat, 3);
    check("t3_data", bus.rsp_data == 8'h00, bus.rsp_data, 0);
    check("t3_irq", bus.rsp_irq == 1'b0, bus.rsp_irq, 0);
    drain();

    // fill: 4 queued plus 1 in flight, then backpressure on the response
    r0 = int'(rsp_count);
    bus.rsp_ready = 1'b0;
    repeat (5) send_rand();
    check("full_after_5", bus.cmd_ready == 1'b0, bus.cmd_ready, 0);
    wait_rsp(lat);
    check("t4_rsp_up", bus.rsp_valid == 1'b1, bus.rsp_valid, 1);
    d0 = bus.rsp_data;
    i0 = bus.rsp_irq;
    bus.cmd_valid = 1'b1;
    bus.cmd_port  = PORT_B;
    bus.cmd_op    = OP2;
    bus.cmd_a     = 8'h7A;
    bus.cmd_b     = 8'h7C;
    repeat (10) begin
      tick();
      check("stall_ready", bus.cmd_ready == 1'b0, bus.cmd_ready, 0);
      check("stall_hold", bus.rsp_valid && bus.rsp_data == d0 && bus.rsp_irq == i0,
            {bus.rsp_valid, bus.rsp_data, bus.rsp_irq}, {1'b1, d0, i0});
      check("stall_no_enable", !bus.alu_enable && !bus.alu_enable_a && !bus.alu_enable_b,
            {bus.alu_enable, bus.alu_enable_a, bus.alu_enable_b}, 0);
    end
    bus.rsp_ready = 1'b1;
    acc = 1'b0;
    lat = 0;
    while (!acc && lat < 100) begin
      acc = bus.cmd_ready;
      tick();
      lat++;
    end
    bus.cmd_valid = 1'b0;
    check("sixth_accept", acc, acc, 1);
    drain();
    check("t4_rsp_count", int'(rsp_count) - r0 == 6, int'(rsp_count) - r0, 6);

    // reset during CAPTURE with two commands queued
    r0 = int'(rsp_count);
    bus.rsp_ready = 1'b0;
    send(PORT_A, OP3, 8'hF0, 8'h08);
    send_rand();
    send_rand();
    alu_rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    tick();
    tick();
    alu_rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) begin
      tick();
      check("post_rst_quiet", !bus.rsp_valid && !bus.alu_enable && bus.cmd_ready,
            {bus.rsp_valid, bus.alu_enable, bus.cmd_ready}, 3'b001);
    end
    check("post_rst_no_rsp", rsp_count == r0, rsp_count, r0);

    // three commands, one with interrupt
    send(PORT_A, OP3, 8'hF0, 8'h08);
    send(PORT_A, OP1, 8'h55, 8'h00);
    send(PORT_B, OP2, 8'h01, 8'h02);
    drain();
`ifdef ALU_SEQ_STATS_EN
    check("stats_cmd", cnt_cmd == CNT_W'(3), cnt_cmd, 3);
    check("stats_irq", cnt_irq == CNT_W'(1), cnt_irq, 1);
`else
    check("stats_off", cnt_cmd == '0 && cnt_irq == '0, {cnt_cmd, cnt_irq}, 0);
`endif

    // randomized traffic with random response backpressure
    r0 = int'(rsp_count);
    done = 1'b0;
    fork
      begin
        repeat (150) begin
          repeat ($urandom_range(0, 3)) tick();
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus.rsp_ready = 1'b1;
    drain();
    check("rand_rsp_count", int'(rsp_count) - r0 == 150, int'(rsp_count) - r0, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
